// File: rtl/crypto_block_endpoint_if.sv
// Bundle between the register side, the crypto endpoint and the external round datapath.
// The endpoint uses the slave modport; the register side and round core together use master.
interface crypto_block_endpoint_if #(
    parameter int TEXT_WIDTH   = 128,
    parameter int KEY_WIDTH    = 128,
    parameter int CIPHER_WIDTH = 128,
    parameter int IDX_WIDTH    = 4
);
    logic                    crypto_start;
    logic [TEXT_WIDTH-1:0]   crypto_textout;
    logic [KEY_WIDTH-1:0]    crypto_keyout;
    logic [CIPHER_WIDTH-1:0] crypto_cipherin;
    logic                    crypto_ready;
    logic                    crypto_done;
    logic                    crypto_idle;

    logic                    core_load;
    logic [TEXT_WIDTH-1:0]   core_text;
    logic [KEY_WIDTH-1:0]    core_key;
    logic                    core_round_en;
    logic [IDX_WIDTH-1:0]    core_round_idx;
    logic                    core_last;
    logic                    core_dummy;
    logic [CIPHER_WIDTH-1:0] core_state_in;

    modport master (
        output crypto_start, crypto_textout, crypto_keyout, core_state_in,
        input  crypto_cipherin, crypto_ready, crypto_done, crypto_idle,
        input  core_load, core_text, core_key, core_round_en, core_round_idx,
        input  core_last, core_dummy
    );

    modport slave (
        input  crypto_start, crypto_textout, crypto_keyout, core_state_in,
        output crypto_cipherin, crypto_ready, crypto_done, crypto_idle,
        output core_load, core_text, core_key, core_round_en, core_round_idx,
        output core_last, core_dummy
    );
endinterface

// File: rtl/crypto_block_endpoint.sv
// Sequences an external iterative round core: load, NUM_ROUNDS rounds, capture of the result.
// Optional macro CRYPTO_DUMMY_ROUNDS_EN inserts LFSR-driven dummy rounds before each real round.
module crypto_block_endpoint #(
    parameter int          TEXT_WIDTH   = 128,
    parameter int          KEY_WIDTH    = 128,
    parameter int          CIPHER_WIDTH = 128,
    parameter int          NUM_ROUNDS   = 10,
    parameter int          IDX_WIDTH    = 4,
    parameter int          DUMMY_BITS   = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input logic                     crypto_clk,
    input logic                     crypto_rst,
    crypto_block_endpoint_if.slave  bus
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMMY,
        S_FINISH
    } state_t;

    state_t                  state;
    logic                    ready_r;
    logic                    idle_r;
    logic                    done_r;
    logic [CIPHER_WIDTH-1:0] cipher_r;
    logic                    load_r;
    logic [TEXT_WIDTH-1:0]   text_r;
    logic [KEY_WIDTH-1:0]    key_r;
    logic                    round_en_r;
    logic [IDX_WIDTH-1:0]    idx_r;
    logic                    last_r;
    logic [IDX_WIDTH-1:0]    next_idx;

    // Index of the real round whose slot is entered on this edge.
    assign next_idx = (state == S_LOAD) ? IDX_WIDTH'(1) : idx_r + IDX_WIDTH'(1);

`ifdef CRYPTO_DUMMY_ROUNDS_EN
    logic [15:0]           lfsr_r;
    logic [DUMMY_BITS-1:0] n_dummy;
    logic [DUMMY_BITS-1:0] dcnt_r;
    logic [IDX_WIDTH-1:0]  pend_idx_r;
    logic                  dummy_r;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign n_dummy = lfsr_r[DUMMY_BITS-1:0];

    always_ff @(posedge crypto_clk) begin
        if (crypto_rst) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    always_ff @(posedge crypto_clk) begin
        if (crypto_rst) begin
            state      <= S_IDLE;
            ready_r    <= 1'b1;
            idle_r     <= 1'b1;
            done_r     <= 1'b0;
            cipher_r   <= '0;
            load_r     <= 1'b0;
            text_r     <= '0;
            key_r      <= '0;
            round_en_r <= 1'b0;
            idx_r      <= '0;
            last_r     <= 1'b0;
            dummy_r    <= 1'b0;
            dcnt_r     <= '0;
            pend_idx_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.crypto_start) begin
                        text_r  <= bus.crypto_textout;
                        key_r   <= bus.crypto_keyout;
                        done_r  <= 1'b0;
                        ready_r <= 1'b0;
                        idle_r  <= 1'b0;
                        load_r  <= 1'b1;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD, S_RUN: begin
                    load_r <= 1'b0;
                    if (state == S_RUN && last_r) begin
                        round_en_r <= 1'b0;
                        idx_r      <= '0;
                        last_r     <= 1'b0;
                        state      <= S_FINISH;
                    end else if (n_dummy != '0) begin
                        // Dummy cycles precede the real round; its index waits in pend_idx_r.
                        round_en_r <= 1'b1;
                        dummy_r    <= 1'b1;
                        idx_r      <= '0;
                        last_r     <= 1'b0;
                        dcnt_r     <= n_dummy - DUMMY_BITS'(1);
                        pend_idx_r <= next_idx;
                        state      <= S_DUMMY;
                    end else begin
                        round_en_r <= 1'b1;
                        dummy_r    <= 1'b0;
                        idx_r      <= next_idx;
                        last_r     <= (next_idx == LAST_IDX);
                        state      <= S_RUN;
                    end
                end
                S_DUMMY: begin
                    if (dcnt_r == '0) begin
                        dummy_r <= 1'b0;
                        idx_r   <= pend_idx_r;
                        last_r  <= (pend_idx_r == LAST_IDX);
                        state   <= S_RUN;
                    end else begin
                        dcnt_r <= dcnt_r - DUMMY_BITS'(1);
                    end
                end
                S_FINISH: begin
                    cipher_r <= bus.core_state_in;
                    done_r   <= 1'b1;
                    ready_r  <= 1'b1;
                    idle_r   <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.core_dummy = dummy_r;
`else
    // Dummy-round configuration is inert in this build.
    logic unused_cfg;
    assign unused_cfg = ^{DUMMY_BITS[0], LFSR_SEED};

    always_ff @(posedge crypto_clk) begin
        if (crypto_rst) begin
            state      <= S_IDLE;
            ready_r    <= 1'b1;
            idle_r     <= 1'b1;
            done_r     <= 1'b0;
            cipher_r   <= '0;
            load_r     <= 1'b0;
            text_r     <= '0;
            key_r      <= '0;
            round_en_r <= 1'b0;
            idx_r      <= '0;
            last_r     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.crypto_start) begin
                        text_r  <= bus.crypto_textout;
                        key_r   <= bus.crypto_keyout;
                        done_r  <= 1'b0;
                        ready_r <= 1'b0;
                        idle_r  <= 1'b0;
                        load_r  <= 1'b1;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD, S_RUN: begin
                    load_r <= 1'b0;
                    if (state == S_RUN && last_r) begin
                        round_en_r <= 1'b0;
                        idx_r      <= '0;
                        last_r     <= 1'b0;
                        state      <= S_FINISH;
                    end else begin
                        round_en_r <= 1'b1;
                        idx_r      <= next_idx;
                        last_r     <= (next_idx == LAST_IDX);
                        state      <= S_RUN;
                    end
                end
                S_FINISH: begin
                    cipher_r <= bus.core_state_in;
                    done_r   <= 1'b1;
                    ready_r  <= 1'b1;
                    idle_r   <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.core_dummy = 1'b0;
`endif

    assign bus.crypto_cipherin = cipher_r;
    assign bus.crypto_ready    = ready_r;
    assign bus.crypto_done     = done_r;
    assign bus.crypto_idle     = idle_r;
    assign bus.core_load       = load_r;
    assign bus.core_text       = text_r;
    assign bus.core_key        = key_r;
    assign bus.core_round_en   = round_en_r;
    assign bus.core_round_idx  = idx_r;
    assign bus.core_last       = last_r;

endmodule
